// File: rtl/hms_pkg.sv
// Shared types and constants for the parameterised h:m:s clock.
package hms_pkg;

  typedef enum logic [1:0] {CLOCK = 2'd0, SETUP = 2'd1, ALARM = 2'd2} mode_e;
  typedef enum logic [1:0] {SEC = 2'd0, MIN = 2'd1, HOUR = 2'd2} pos_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop sync, strobed sampling, one-cycle press pulse.
module btn_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic smp,
  output logic press
);

  logic [1:0] sync;
  logic       last;
  logic       rel;

  // A press needs two consecutive low samples and a high sample since the last press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      last  <= 1'b1;
      rel   <= 1'b1;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (smp) begin
        last <= sync[1];
        if (sync[1]) rel <= 1'b1;
        else if (!last && rel) begin
          press <= 1'b1;
          rel   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/param_hms_clock.sv
// Hours/minutes/seconds clock with setup mode; alarm built only with HMS_ALARM_EN.
module param_hms_clock
  import hms_pkg::*;
#(
  parameter int CLK_DIV  = 50000000,
  parameter int DEB_DIV  = 500000,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_tick,
  output logic       o_alarm,
  output logic       o_alarm_armed
);

  localparam int NUM_BTN = 4;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [5:0] HOUR_TOP = 6'(HOUR_MAX - 1);

  logic [NUM_BTN-1:0] btn_n, press;
  logic [DW-1:0]      deb_cnt;
  logic               smp_stb;
  logic [CW-1:0]      tick_cnt;
  logic               tick_ev;
  mode_e              mode, mode_nx;
  pos_e               pos;
  hms_t               tm, tm_nx;
  logic               mode_chg, in_setup, in_clock;
  logic               p0, p1, p2;

  assign btn_n   = {i_sw3, i_sw2, i_sw1, i_sw0};
  assign smp_stb = (deb_cnt == DW'(DEB_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       deb_cnt <= '0;
    else if (smp_stb) deb_cnt <= '0;
    else              deb_cnt <= deb_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_cond u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_n[gi]),
      .smp   (smp_stb),
      .press (press[gi])
    );
  end

  // sw0 wins outright; sw1 beats sw2.
  assign p0 = press[0];
  assign p1 = press[1] & ~p0;
  assign p2 = press[2] & ~p0 & ~p1;

  // Mode FSM: state register, next state, decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode <= CLOCK;
    else        mode <= mode_nx;
  end

  always_comb begin
    mode_nx = mode;
    case (mode)
      CLOCK: if (p0) mode_nx = SETUP;
`ifdef HMS_ALARM_EN
      SETUP: if (p0) mode_nx = ALARM;
      ALARM: if (p0) mode_nx = CLOCK;
`else
      SETUP: if (p0) mode_nx = CLOCK;
      ALARM: mode_nx = CLOCK;
`endif
      default: mode_nx = CLOCK;
    endcase
  end

  always_comb begin
    in_setup = (mode == SETUP);
    in_clock = (mode == CLOCK);
    mode_chg = (mode_nx != mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= SEC;
    else if (mode_chg) pos <= SEC;
    else if (p1 && !in_clock) begin
      case (pos)
        SEC:     pos <= MIN;
        MIN:     pos <= HOUR;
        default: pos <= SEC;
      endcase
    end
  end

  assign tick_ev = (tick_cnt == CW'(CLK_DIV - 1)) && !in_setup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      o_sec_tick <= 1'b0;
    end else begin
      o_sec_tick <= tick_ev;
      if (in_setup || tick_ev) tick_cnt <= '0;
      else                     tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    tm_nx = tm;
    if (tick_ev) begin
      tm_nx.sec = wrap_inc(tm.sec, SEC_MAX);
      if (tm.sec >= SEC_MAX) begin
        tm_nx.min = wrap_inc(tm.min, MIN_MAX);
        if (tm.min >= MIN_MAX) tm_nx.hour = 5'(wrap_inc({1'b0, tm.hour}, HOUR_TOP));
      end
    end else if (in_setup && p2) begin
      case (pos)
        SEC:     tm_nx.sec  = wrap_inc(tm.sec, SEC_MAX);
        MIN:     tm_nx.min  = wrap_inc(tm.min, MIN_MAX);
        HOUR:    tm_nx.hour = 5'(wrap_inc({1'b0, tm.hour}, HOUR_TOP));
        default: tm_nx = tm;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tm <= '0;
    else        tm <= tm_nx;
  end

  assign o_sec      = tm.sec;
  assign o_min      = tm.min;
  assign o_hour     = tm.hour;
  assign o_mode     = mode;
  assign o_position = pos;

`ifdef HMS_ALARM_EN
  logic [5:0] al_min, ring_cnt;
  logic [4:0] al_hour;
  logic       armed, ring, p3, hit;

  assign p3  = press[3] & ~p0;
  assign hit = (tm_nx.sec == 6'd0) && (tm_nx.min == al_min) && (tm_nx.hour == al_hour);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_min   <= '0;
      al_hour  <= '0;
      armed    <= 1'b0;
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else begin
      if ((mode == ALARM) && p2) begin
        if (pos == MIN)  al_min  <= wrap_inc(al_min, MIN_MAX);
        if (pos == HOUR) al_hour <= 5'(wrap_inc({1'b0, al_hour}, HOUR_TOP));
      end
      if (p3 && !ring) armed <= ~armed;
      // Ring is silenced by ack, mode change, or the 60th tick after it started.
      if (p3 || mode_chg || (ring && tick_ev && ring_cnt == 6'd59)) ring <= 1'b0;
      else if (!ring && tick_ev && armed && in_clock && hit) begin
        ring     <= 1'b1;
        ring_cnt <= '0;
      end else if (ring && tick_ev) ring_cnt <= ring_cnt + 6'd1;
    end
  end

  assign o_alarm       = ring;
  assign o_alarm_armed = armed;
`else
  logic unused_sw3;
  assign unused_sw3    = press[3];
  assign o_alarm       = 1'b0;
  assign o_alarm_armed = 1'b0;
`endif

endmodule

// File: doc/param_hms_clock.md
PARAM_HMS_CLOCK -- requirements
Module: param_hms_clock

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000: clk cycles per 1 s tick.
REQ-002 SHALL have parameter DEB_DIV, default 500000: clk cycles per button sample (100 Hz).
REQ-003 SHALL have parameter HOUR_MAX, default 24: hour count modulus, legal values 12 or 24.
REQ-004 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: i_sw0 in 1, mode button; i_sw1 in 1, position button; i_sw2 in 1, increment button; i_sw3 in 1, alarm button. All buttons are active-low and asynchronous.
REQ-006 SHALL have ports: o_sec out 6; o_min out 6; o_hour out 5; o_mode out 2; o_position out 2; o_sec_tick out 1, one-cycle 1 Hz pulse; o_alarm out 1, ringing; o_alarm_armed out 1.

Function
REQ-007 SHALL synchronise each button through two flops and sample it every DEB_DIV cycles; a press SHALL be accepted when two consecutive samples read 0 after a released state; one-cycle press pulse.
REQ-008 SHALL run a tick counter 0..CLK_DIV-1 whose last count pulses o_sec_tick; counter held at 0 in SETUP.
REQ-009 SHALL, on o_sec_tick, increment o_sec in the same cycle; 59->0 carries to o_min in the same cycle; min 59->0 carries to o_hour; hour HOUR_MAX-1->0 with no further carry.
REQ-010 SHALL implement mode FSM CLOCK(0)->SETUP(1)->ALARM(2)->CLOCK on each sw0 press; encoding 3 illegal, recovers to CLOCK next cycle.
REQ-011 SHALL set o_position to SEC(0) on every mode change; sw1 press cycles SEC->MIN(1)->HOUR(2)->SEC in SETUP and ALARM only, ignored in CLOCK.
REQ-012 SHALL, in SETUP, on sw2 press add 1 to selected time field modulo its range, no carry into other fields.
REQ-013 SHALL, in ALARM mode, on sw2 press add 1 to selected alarm field (alarm min 0..59, alarm hour 0..HOUR_MAX-1); ignore press when position SEC; timekeeping continues.
REQ-014 SHALL, when sw3 pressed and o_alarm=0, toggle o_alarm_armed.
REQ-015 SHALL set o_alarm on the tick cycle where the new time equals alarm hour:min:00, o_alarm_armed=1, mode is CLOCK.
REQ-016 SHALL clear o_alarm on sw3 press (armed unchanged), on any mode change, or after 60 ticks of ringing; a sw3 press that clears o_alarm SHALL not toggle armed.
REQ-017 SHALL, on same-cycle presses, give sw0 priority and drop sw1/sw2/sw3 that cycle; sw1 beats sw2.
REQ-018 SHALL let a SETUP increment landing on the same cycle as no tick (ticks absent in SETUP) proceed without conflict; in ALARM mode ticks and alarm-field increments SHALL both take effect.
REQ-019 SHALL drive all outputs directly from flops; zero-cycle combinational paths from inputs to outputs are forbidden.

Reset
REQ-020 SHALL, on rst_n low, asynchronously reset: time 00:00:00, alarm 00:00, tick and sample counters 0, mode CLOCK, position SEC, o_sec_tick 0, o_alarm 0, o_alarm_armed 0, button state released.
REQ-021 SHALL, on reset asserted mid-press or mid-ring, discard the press and ringing; after release, the first tick SHALL occur CLK_DIV cycles later.

Configuration
REQ-022 SHALL compile the alarm feature only under macro HMS_ALARM_EN.
REQ-023 SHALL, without HMS_ALARM_EN, cycle the mode FSM CLOCK<->SETUP only; tie o_alarm and o_alarm_armed to 0; ignore i_sw3; omit alarm registers.

Structure
REQ-024 SHALL place mode enum (CLOCK, SETUP, ALARM), position enum (SEC, MIN, HOUR), and constant SEC_MAX=59 / MIN_MAX=59 in shared package hms_pkg.
REQ-025 SHALL instantiate sub-module btn_cond (sync, debounce, press pulse) once per button, sharing one DEB_DIV sample strobe.

Verification (CLK_DIV=10, DEB_DIV=2, HOUR_MAX=24)
REQ-026 SHALL test wrap: preload 23:59:59 via SETUP, return to CLOCK, 1 tick -> 00:00:00; o_sec_tick width exactly 1 cycle.
REQ-027 SHALL test setup: sw0 x1, sw1 x1, sw2 x3 from 00:00:00 -> min=3, sec frozen at 0 with no ticks; min 59 + sw2 -> min 0, hour unchanged.
REQ-028 SHALL test priority: sw0 and sw2 pressed same sample in SETUP -> mode ALARM, position SEC, no field changes.
REQ-029 SHALL test alarm: set alarm 00:01, arm, run from 00:00:00 -> o_alarm rises on tick to 00:01:00; sw3 press -> o_alarm 0, armed stays 1; unacked ring clears after 60 ticks.
REQ-030 SHALL test bounce: sw2 low for one sample only -> no increment; low for two samples -> exactly one increment.
REQ-031 SHALL test reset: rst_n pulsed low while ringing at 00:01:05 -> all outputs reset value immediately, first tick 10 cycles after release.
